// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - FIFO-buffered left-justified serial DAC transmitter with frame strobe
// Pops one sample per frame and sends it MSB-first in both lrclk slots.
module dac_serial_tx #(
  parameter int DATA_W     = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              clr_flags,
  output logic              sample,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic              overflow
);

  localparam int DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W  = $clog2(2 * DATA_W);
  localparam int SLOT_W = $clog2(DATA_W);
  localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(2 * DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_SLOT = BIT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [SLOT_W-1:0] SLOT_MSB = SLOT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_sample;
  logic                r_bclk;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_underrun;
  logic                r_overflow;

  logic                w_active;
  logic                w_div_last;
  logic                w_frame_end;
  logic                w_wrap;
  logic                w_fs;
  logic                w_stop;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   w_word_nxt;
  logic [SLOT_W-1:0]   w_slot;
  logic                w_sdata_nxt;

  assign w_active    = (r_state != S_IDLE);
  assign w_div_last  = (r_div == DIV_LAST);
  assign w_frame_end = w_active && w_div_last && (r_bit == BIT_LAST);
  // Leaving IDLE behaves like a counter wrap so the first frame starts on the entry edge
  assign w_wrap      = !w_active || w_div_last;
  assign w_fs        = en && (!w_active || w_frame_end);
  assign w_stop      = !en && (!w_active || w_frame_end);

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = din_valid && !w_full;
  assign w_pop       = w_fs && !w_empty;
  assign din_ready   = !w_full;

  assign w_div_nxt   = w_wrap ? '0 : r_div + 1'b1;
  assign w_bit_nxt   = (!w_active || w_frame_end) ? '0 :
                       (w_div_last ? r_bit + 1'b1 : r_bit);
  assign w_word_nxt  = w_fs ? (w_empty ? '0 : r_mem[r_rd_ptr]) : r_word;
  assign w_slot      = (w_bit_nxt >= BIT_SLOT) ? SLOT_W'(w_bit_nxt - BIT_SLOT)
                                               : SLOT_W'(w_bit_nxt);
  assign w_sdata_nxt = w_word_nxt[SLOT_MSB - w_slot];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_word     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sample   <= 1'b0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_sample   <= w_fs;
      // A set event in the same cycle as clr_flags wins
      r_underrun <= (w_fs && w_empty) || (r_underrun && !clr_flags);
      r_overflow <= (din_valid && w_full) || (r_overflow && !clr_flags);
      if (w_stop) begin
        r_state <= S_IDLE;
        r_div   <= '0;
        r_bit   <= '0;
        r_bclk  <= 1'b0;
        r_lrclk <= 1'b0;
        r_sdata <= 1'b0;
      end else begin
        r_state <= en ? S_RUN : S_DRAIN;
        r_div   <= w_div_nxt;
        r_bit   <= w_bit_nxt;
        r_word  <= w_word_nxt;
        r_bclk  <= (w_div_nxt >= DIV_HALF);
        if (w_wrap) begin
          r_lrclk <= (w_bit_nxt >= BIT_SLOT);
          r_sdata <= w_sdata_nxt;
        end
      end
    end
  end

  assign sample   = r_sample;
  assign bclk     = r_bclk;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - self-checking bench for dac_serial_tx
// Frame-time reference model checked every cycle, plus directed scenario checks.
module tb_dac_serial_tx;

  localparam int DATA_W     = 16;
  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 2 * DATA_W * BCLK_DIV;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              clr_flags;
  logic              sample;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              underrun;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  dac_serial_tx #(
    .DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .clr_flags(clr_flags), .sample(sample), .bclk(bclk),
    .lrclk(lrclk), .sdata(sdata), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: time within frame, sample queue, current word, flags
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_word;
  bit                m_on;
  int                m_t;
  bit                m_und, m_ovf, m_smp;

  function automatic void model_reset();
    m_q.delete();
    m_word = '0;
    m_on   = 0;
    m_t    = 0;
    m_und  = 0;
    m_ovf  = 0;
    m_smp  = 0;
  endfunction

  function automatic void model_edge(input logic e, input logic v,
                                     input logic [DATA_W-1:0] d, input logic c);
    bit full_b, empty_b, fs;
    full_b  = (m_q.size() == FIFO_DEPTH);
    empty_b = (m_q.size() == 0);
    fs      = 0;
    if (!m_on) begin
      if (e) begin fs = 1; m_on = 1; m_t = 0; end
    end else if (m_t == FRAME - 1) begin
      m_t = 0;
      if (e) fs = 1; else m_on = 0;
    end else begin
      m_t++;
    end
    if (fs) begin
      if (empty_b) m_word = '0;
      else         m_word = m_q.pop_front();
    end
    if (v && !full_b) m_q.push_back(d);
    m_und = (fs && empty_b) || (m_und && !c);
    m_ovf = (v && full_b) || (m_ovf && !c);
    m_smp = fs;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic b, l, s;
    logic [DATA_W-1:0] sh;
    int bitn;
    b = 0; l = 0; s = 0;
    if (m_on) begin
      bitn = m_t / BCLK_DIV;
      b    = (m_t % BCLK_DIV) >= BCLK_DIV / 2;
      l    = bitn >= DATA_W;
      sh   = m_word >> (DATA_W - 1 - (bitn % DATA_W));
      s    = sh[0];
    end
    return {m_smp, b, l, s, m_und, m_ovf, m_q.size() < FIFO_DEPTH};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {sample, bclk, lrclk, sdata, underrun, overflow, din_ready};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    logic e, v, c, r;
    logic [DATA_W-1:0] d;
    e = en; v = din_valid; c = clr_flags; r = reset_n; d = din;
    @(posedge clk);
    if (!r) model_reset();
    else    model_edge(e, v, d, c);
    #1;
    check("cyc", {25'b0, obs_vec()}, {25'b0, exp_vec()});
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    din = d; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; din_valid = 1'b0; clr_flags = 1'b0;
    #1;
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  // Called in the FS cycle; returns in the cycle after the following frame boundary
  task automatic capture_frame(input logic [DATA_W-1:0] w, input string tag);
    logic [2*DATA_W-1:0] bits;
    bits = '0;
    check({tag, "_fs"}, {31'b0, sample}, 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      if (k % BCLK_DIV == BCLK_DIV / 2) bits = {bits[2*DATA_W-2:0], sdata};
      step();
    end
    check({tag, "_bits"}, bits, {w, w});
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0; clr_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vals", {25'b0, obs_vec()}, 32'h01);
    reset_n = 1'b1;

    // Serialization
    push_word(16'hA5C3);
    en = 1'b1;
    step();
    capture_frame(16'hA5C3, "t1");

    // Ordering
    do_reset();
    push_word(16'h8000); push_word(16'h7FFF); push_word(16'h0001);
    en = 1'b1;
    step();
    capture_frame(16'h8000, "t2a");
    capture_frame(16'h7FFF, "t2b");
    capture_frame(16'h0001, "t2c");

    // Underrun and flag clear
    do_reset();
    en = 1'b1;
    step();
    capture_frame(16'h0000, "t3");
    check("t3_und", {31'b0, underrun}, 32'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("t3_clr", {31'b0, underrun}, 32'd0);

    // Overflow
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push_word(DATA_W'(i));
      if (i == 4) check("t4_ready", {31'b0, din_ready}, 32'd0);
    end
    check("t4_ovf", {31'b0, overflow}, 32'd1);
    en = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) capture_frame(DATA_W'(i), "t4");
    capture_frame(16'h0000, "t4_mute");

    // Stop and drain
    do_reset();
    push_word(16'h1234);
    en = 1'b1;
    step();
    repeat (5 * BCLK_DIV) step();
    en = 1'b0;
    repeat (FRAME - 5 * BCLK_DIV) step();
    check("t5_idle", {28'b0, sample, bclk, lrclk, sdata}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | sample;
    end
    check("t5_nopulse", {31'b0, seen}, 32'd0);
    en = 1'b1;
    step();
    check("t5_restart", {31'b0, sample}, 32'd1);

    // Reset mid-frame
    do_reset();
    push_word(16'hBEEF);
    push_word(16'h4321);
    en = 1'b1;
    step();
    repeat (20 * BCLK_DIV) step();
    reset_n = 1'b0;
    #1;
    check("t6_reset", {25'b0, obs_vec()}, 32'h01);
    model_reset();
    en = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("t6_ready", {31'b0, din_ready}, 32'd1);
    en = 1'b1;
    step();
    check("t6_empty", {31'b0, underrun}, 32'd1);

    // Randomized traffic against the model
    do_reset();
    en = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      din       = DATA_W'($urandom);
      din_valid = (n < 3000) ? ($urandom_range(0, 159) == 0) : ($urandom_range(0, 79) == 0);
      clr_flags = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 249) == 0) en = ~en;
      step();
    end
    din_valid = 1'b0;
    clr_flags = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
